mem_arbiter: RTL and testbench

Sequencer and arbiter for the single byte-wide RAM/IO port shared by the instruction cache (fetch) and the load/store buffer (data). It accepts one word fetch or one sized data access at a time and serialises it into byte beats on the external memory bus. Read data is assembled little-endian and returned as a 32-bit word. Memory-mapped UART stores are held off while the UART buffer is full. It sits between IC/LSB and the top-level mem_a/mem_din/mem_dout/mem_wr pins.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-port sequencer: FSM states, access-size
// encodings and the memory-mapped IO page.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STORE
  } arb_state_e;

  // d_size encodings
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Address bits [17:16] == IO_PAGE select the memory-mapped IO space
  localparam logic [1:0]  IO_PAGE      = 2'b11;
  localparam logic [31:0] IO_UART_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_UART_STAT = 32'h0003_0004;

  // Number of byte beats for a data access; the unused code 3 is treated as word
  function automatic logic [2:0] beats_for(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_PAGE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide memory port between instruction fetch and
// the load/store buffer, serialising each access into byte beats and
// assembling read data little-endian.
module mem_arbiter
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  arb_state_e  state;
  logic [2:0]  k;          // reads: cycle index within access; stores: beats issued
  logic [2:0]  n_beats;
  logic [31:0] base;
  logic [31:0] wdata_q;
  logic [31:0] rd_buf;
  logic        last_data;  // 1 = the most recent grant went to the data side

  // When rdy drops, the byte already on ram_din would be overwritten by the
  // held address before it is consumed; keep it for the first resumed sample.
  logic [7:0]  skid_din;
  logic        skid_vld;

  logic        fetch_ok;
  logic        grant_data;
  logic        grant_fetch;
  logic [7:0]  din_eff;
  logic [1:0]  lane_idx;
  logic [31:0] buf_next;
  logic        io_stall;

  // Grant decision: flush masks fetch, and on a tie the side not granted last wins
  always_comb begin
    fetch_ok    = if_req & ~flush;
    grant_data  = d_req & (~fetch_ok | ~last_data);
    grant_fetch = fetch_ok & ~grant_data;
  end

  // Insert the returning byte into its lane of the read buffer
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    buf_next = rd_buf;
    din_eff  = skid_vld ? skid_din : ram_din;
    lane_idx = k[1:0] - 2'd2;  // byte addressed in cycle j+1 returns in cycle j+2
    buf_next[{lane_idx, 3'b000} +: 8] = din_eff;
    io_stall = is_io(base) & io_buffer_full;
  end

  // Sequencer FSM with registered memory-bus and completion outputs
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      n_beats   <= '0;
      base      <= '0;
      wdata_q   <= '0;
      rd_buf    <= '0;
      last_data <= 1'b0;
      skid_din  <= '0;
      skid_vld  <= 1'b0;
      if_valid  <= 1'b0;
      if_data   <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      ram_dout  <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
    end else if (!rdy) begin
      ram_wr <= 1'b0;
      if (!skid_vld) begin
        skid_din <= ram_din;
        skid_vld <= 1'b1;
      end
    end else begin
      skid_vld <= 1'b0;
      if_valid <= 1'b0;
      d_done   <= 1'b0;
      ram_wr   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_data) begin
            last_data <= 1'b1;
            base      <= d_addr;
            wdata_q   <= d_wdata;
            n_beats   <= beats_for(d_size);
            rd_buf    <= '0;
            ram_addr  <= d_addr;
            if (d_we) begin
              state <= ST_STORE;
              if (is_io(d_addr) && io_buffer_full) begin
                k <= 3'd0;
              end else begin
                ram_wr   <= 1'b1;
                ram_dout <= d_wdata[7:0];
                k        <= 3'd1;
              end
            end else begin
              state <= ST_LOAD;
              k     <= 3'd1;
            end
          end else if (grant_fetch) begin
            last_data <= 1'b0;
            base      <= if_addr;
            n_beats   <= 3'd4;
            rd_buf    <= '0;
            ram_addr  <= if_addr;
            k         <= 3'd1;
            state     <= ST_FETCH;
          end
        end

        ST_FETCH, ST_LOAD: begin
          if (state == ST_FETCH && flush) begin
            state <= ST_IDLE;
          end else begin
            if (k < n_beats) ram_addr <= base + 32'(k);
            if (k >= 3'd2)   rd_buf   <= buf_next;
            if (k == n_beats + 3'd1) begin
              state <= ST_IDLE;
              if (state == ST_FETCH) begin
                if_valid <= 1'b1;
                if_data  <= buf_next;
              end else begin
                d_done  <= 1'b1;
                d_rdata <= buf_next;
              end
            end else begin
              k <= k + 3'd1;
            end
          end
        end

        ST_STORE: begin
          if (k == n_beats) begin
            d_done <= 1'b1;
            state  <= ST_IDLE;
          end else if (!io_stall) begin
            ram_wr   <= 1'b1;
            ram_addr <= base + 32'(k);
            ram_dout <= wdata_q[{k[1:0], 3'b000} +: 8];
            k        <= k + 3'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model with one-cycle read
// latency, hand-written corner-case sequences and a table of data accesses.
module tb_mem_arbiter;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic        io_buffer_full;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:4095];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after the address
  always @(posedge clk) begin
    ram_din <= mem[ram_addr[11:0]];
    if (ram_wr) mem[ram_addr[11:0]] = ram_dout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_data(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    lat = -1; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (d_done) begin
        lat = c;
        rd  = d_rdata;
        break;
      end
    end
    d_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd;
    int lat, done_c, val_c;
    logic saw;

    vecs[0]  = '{1'b1, SZ_W, 32'h0000_0300, 32'h0403_0201, 32'h0,         5};
    vecs[1]  = '{1'b0, SZ_W, 32'h0000_0300, 32'h0,         32'h0403_0201, 6};
    vecs[2]  = '{1'b0, SZ_B, 32'h0000_0302, 32'h0,         32'h0000_0003, 3};
    vecs[3]  = '{1'b0, SZ_H, 32'h0000_0301, 32'h0,         32'h0000_0302, 4};
    vecs[4]  = '{1'b1, SZ_H, 32'h0000_0304, 32'hAABB_CCDD, 32'h0,         3};
    vecs[5]  = '{1'b0, SZ_W, 32'h0000_0304, 32'h0,         32'h0000_CCDD, 6};
    vecs[6]  = '{1'b1, SZ_B, 32'h0000_0307, 32'h1111_117F, 32'h0,         2};
    vecs[7]  = '{1'b0, SZ_W, 32'h0000_0304, 32'h0,         32'h7F00_CCDD, 6};
    vecs[8]  = '{1'b1, SZ_H, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0,         3};
    vecs[9]  = '{1'b0, SZ_H, 32'hFFFF_FFFF, 32'h0,         32'h0000_1234, 4};
    vecs[10] = '{1'b1, SZ_B, 32'h0003_0004, 32'h0000_005A, 32'h0,         2};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h00; mem[12'h103] = 8'h00;
    mem[12'h104] = 8'h93; mem[12'h105] = 8'h00; mem[12'h106] = 8'h10; mem[12'h107] = 8'h00;
    mem[12'h200] = 8'h11; mem[12'h201] = 8'h22; mem[12'h202] = 8'h33; mem[12'h203] = 8'h44;
    mem[12'h1FE] = 8'hCD; mem[12'h1FF] = 8'hAB;

    rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = SZ_B; d_addr = '0; d_wdata = '0;

    // Reset values
    tick(); tick();
    check("rst ram_addr", ram_addr, 32'h0);
    check("rst ram_dout", {24'h0, ram_dout}, 32'h0);
    check("rst ram_wr",   {31'h0, ram_wr}, 32'h0);
    check("rst if_valid", {31'h0, if_valid}, 32'h0);
    check("rst d_done",   {31'h0, d_done}, 32'h0);
    check("rst if_data",  if_data, 32'h0);
    check("rst d_rdata",  d_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // Word fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        check($sformatf("fetch addr c%0d", c), ram_addr, 32'h100 + 32'(c - 1));
        check($sformatf("fetch wr c%0d", c), {31'h0, ram_wr}, 32'h0);
      end
      if (c < 6) check($sformatf("fetch early valid c%0d", c), {31'h0, if_valid}, 32'h0);
    end
    check("fetch valid c6", {31'h0, if_valid}, 32'h1);
    check("fetch data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();
    check("fetch valid pulse width", {31'h0, if_valid}, 32'h0);

    // Simultaneous requests after reset: data first, then fetch
    rst = 1'b0; tick(); rst = 1'b1; tick();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_W; d_addr = 32'h200;
    done_c = -1; val_c = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) check("tie grants data", ram_addr, 32'h200);
      if (c == 7) check("fetch after data addr", ram_addr, 32'h100);
      if (d_done && done_c < 0) begin
        done_c = c;
        check("tie load data", d_rdata, 32'h4433_2211);
        d_req = 1'b0;
      end
      if (if_valid) begin
        val_c = c;
        check("tie fetch data", if_data, 32'h0000_0513);
        break;
      end
    end
    if_req = 1'b0;
    check("tie d_done cycle", 32'(done_c), 32'd6);
    check("tie if_valid cycle", 32'(val_c), 32'd12);

    // IO byte store held off by io_buffer_full for three cycles
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_B; d_addr = 32'h0003_0000; d_wdata = 32'hFFFF_FF41;
    io_buffer_full = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 3) check($sformatf("io stall wr c%0d", c), {31'h0, ram_wr}, 32'h0);
      if (c == 3) io_buffer_full = 1'b0;
      if (c == 4) begin
        check("io write wr", {31'h0, ram_wr}, 32'h1);
        check("io write data", {24'h0, ram_dout}, 32'h41);
        check("io write addr", ram_addr, 32'h0003_0000);
        check("io done early", {31'h0, d_done}, 32'h0);
      end
      if (c == 5) begin
        check("io done c5", {31'h0, d_done}, 32'h1);
        check("io wr after", {31'h0, ram_wr}, 32'h0);
      end
    end
    d_req = 1'b0;

    // Flush in cycle 3 of a fetch with a data request pending
    if_req = 1'b1; if_addr = 32'h100;
    saw = 1'b0; done_c = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (if_valid) saw = 1'b1;
      if (c == 1) begin
        d_req = 1'b1; d_we = 1'b0; d_size = SZ_B; d_addr = 32'h200;
      end
      if (c == 3) begin flush = 1'b1; if_req = 1'b0; end
      if (c == 4) flush = 1'b0;
      if (c == 5) check("flush then data addr", ram_addr, 32'h200);
      if (d_done && done_c < 0) begin
        done_c = c;
        check("flush then data rdata", d_rdata, 32'h0000_0011);
        d_req = 1'b0;
      end
    end
    check("flush no if_valid", {31'h0, saw}, 32'h0);
    check("flush data done cycle", 32'(done_c), 32'd7);

    // Flush coinciding with the final fetch beat
    if_req = 1'b1; if_addr = 32'h100; saw = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (if_valid) saw = 1'b1;
      if (c == 5) begin flush = 1'b1; if_req = 1'b0; end
      if (c == 6) flush = 1'b0;
    end
    check("flush last beat no if_valid", {31'h0, saw}, 32'h0);

    // Flush in IDLE masks if_req for that cycle only
    if_req = 1'b1; if_addr = 32'h104; flush = 1'b1; val_c = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      flush = 1'b0;
      if (if_valid) begin
        val_c = c;
        check("masked fetch data", if_data, 32'h0010_0093);
        break;
      end
    end
    if_req = 1'b0;
    check("masked fetch valid cycle", 32'(val_c), 32'd7);

    // Half load at 0x1FE with rdy low in cycles 2-3
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_H; d_addr = 32'h1FE;
    saw = 1'b0; done_c = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ram_wr) saw = 1'b1;
      if (c == 2) rdy = 1'b0;
      if (c == 3) check("rdy low addr held", ram_addr, 32'h1FF);
      if (c == 4) rdy = 1'b1;
      if (d_done) begin
        done_c = c;
        check("rdy load rdata", d_rdata, 32'h0000_ABCD);
        break;
      end
    end
    d_req = 1'b0;
    check("rdy load no write", {31'h0, saw}, 32'h0);
    check("rdy load done cycle", 32'(done_c), 32'd6);

    // Reset during beat 2 of a word store at 0x200
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_W; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    saw = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (d_done) saw = 1'b1;
    end
    check("beat2 addr", ram_addr, 32'h202);
    rst = 1'b0;
    #1;
    check("mid rst ram_wr", {31'h0, ram_wr}, 32'h0);
    check("mid rst ram_addr", ram_addr, 32'h0);
    check("mid rst ram_dout", {24'h0, ram_dout}, 32'h0);
    check("mid rst d_rdata", d_rdata, 32'h0);
    check("mid rst if_data", if_data, 32'h0);
    d_req = 1'b0;
    tick();
    if (d_done) saw = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    if (d_done) saw = 1'b1;
    check("mid rst no d_done", {31'h0, saw}, 32'h0);
    check("mid rst byte0", {24'h0, mem[12'h200]}, 32'hEF);
    check("mid rst byte1", {24'h0, mem[12'h201]}, 32'hBE);
    check("mid rst byte3 kept", {24'h0, mem[12'h203]}, 32'h44);

    // After reset the tie goes to data again
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_B; d_addr = 32'h201;
    val_c = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) check("post rst tie grants data", ram_addr, 32'h201);
      if (d_done) begin
        check("post rst load", d_rdata, 32'h0000_00BE);
        d_req = 1'b0;
      end
      if (if_valid) begin val_c = c; break; end
    end
    if_req = 1'b0;
    check("post rst fetch cycle", 32'(val_c), 32'd9);

    // Table of sized data accesses
    for (int i = 0; i < 11; i++) begin
      run_data(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].we) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
    end
    check("io store byte", {24'h0, mem[12'h004]}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
